// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data access unit: FSM encodings,
// RV64 load/store funct3 values, byte-lane masks and helper functions.
package mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = MASK_B;
            2'd1:    mask = MASK_H;
            2'd2:    mask = MASK_W;
            2'd3:    mask = MASK_D;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

    // Alignment fault or an encoding with no matching load/store.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] offset,
                                        input logic is_store);
        logic bad;
        if (funct3 == F3_ILL) begin
            bad = 1'b1;
        end else if (is_store && funct3[2]) begin
            bad = 1'b1;
        end else begin
            case (funct3[1:0])
                2'd0:    bad = 1'b0;
                2'd1:    bad = offset[0];
                2'd2:    bad = (offset[1:0] != 2'b00);
                2'd3:    bad = (offset != 3'b000);
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed bytes of a read doubleword and sign/zero extends them.
module load_align
    import mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [63:0] data
);

    logic [63:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Extend the selected field to 64 bits.
    always_comb begin
        data = 64'd0;
        case (size)
            2'd0:    data = {{56{~zext & shifted[7]}},  shifted[7:0]};
            2'd1:    data = {{48{~zext & shifted[15]}}, shifted[15:0]};
            2'd2:    data = {{32{~zext & shifted[31]}}, shifted[31:0]};
            2'd3:    data = shifted;
            default: data = 64'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access controller: stalls the pipeline while a load
// or store handshakes with data memory, with a watchdog that abandons stuck accesses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    output logic        stall_o,
    output logic [63:0] mem_data_o,
    output logic        mem_valid_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    output logic [7:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [63:0] dmem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [63:0]      addr_r, wdata_r, mem_data_r, load_data_s;
    logic [7:0]       be_r;
    logic [1:0]       size_r;
    logic             zext_r, we_r, err_r;
    logic             is_mem_s, is_store_s, bad_s, start_s, timeout_s;

    assign is_mem_s   = valid_i & (memread_i | memwrite_i);
    assign is_store_s = memwrite_i & ~memread_i;
    assign bad_s      = misaligned(funct3_i, addr_i[2:0], is_store_s);
    assign start_s    = (state_r == ST_IDLE) & is_mem_s & ~bad_s;

    // Counter reaching its last value without a handshake abandons the access.
    assign timeout_s = (cnt_r == CNT_LAST) &
                       (((state_r == ST_REQ) & ~dmem_gnt_i) |
                        ((state_r == ST_WAIT) & ~dmem_rvalid_i));

    // Next-state selection; grant/rvalid win over a same-cycle timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nxt_s = ST_REQ;
                else         state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (dmem_gnt_i)     state_nxt_s = we_r ? ST_RESP : ST_WAIT;
                else if (timeout_s) state_nxt_s = ST_RESP;
                else                state_nxt_s = ST_REQ;
            end
            ST_WAIT: begin
                if (dmem_rvalid_i || timeout_s) state_nxt_s = ST_RESP;
                else                            state_nxt_s = ST_WAIT;
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata  (dmem_rdata_i),
        .offset (addr_r[2:0]),
        .size   (size_r),
        .zext   (zext_r),
        .data   (load_data_s)
    );

    // FSM, watchdog counter, request latches and load result register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            addr_r     <= 64'd0;
            wdata_r    <= 64'd0;
            be_r       <= 8'd0;
            size_r     <= 2'd0;
            zext_r     <= 1'b0;
            we_r       <= 1'b0;
            err_r      <= 1'b0;
            mem_data_r <= 64'd0;
        end else begin
            state_r <= state_nxt_s;
            err_r   <= timeout_s;
            if (start_s) begin
                cnt_r   <= '0;
                addr_r  <= addr_i;
                wdata_r <= wdata_i << {addr_i[2:0], 3'b000};
                be_r    <= size_mask(funct3_i[1:0]) << addr_i[2:0];
                size_r  <= funct3_i[1:0];
                zext_r  <= funct3_i[2];
                we_r    <= is_store_s;
            end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if (timeout_s) begin
                mem_data_r <= 64'd0;
            end else if ((state_r == ST_WAIT) && dmem_rvalid_i) begin
                mem_data_r <= load_data_s;
            end else begin
                mem_data_r <= mem_data_r;
            end
        end
    end

    assign stall_o      = start_s | (state_r == ST_REQ) | (state_r == ST_WAIT);
    assign mem_valid_o  = (state_r == ST_RESP);
    assign err_o        = err_r;
    assign mem_data_o   = mem_data_r;
    assign misalign_o   = (state_r == ST_IDLE) & is_mem_s & bad_s;
    assign dmem_req_o   = (state_r == ST_REQ);
    assign dmem_we_o    = (state_r == ST_REQ) & we_r;
    assign dmem_addr_o  = {addr_r[63:3], 3'b000};
    assign dmem_wdata_o = wdata_r;
    assign dmem_be_o    = (state_r == ST_REQ) ? be_r : 8'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i, memread_i, memwrite_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i, wdata_i;
    logic        stall_o, mem_valid_o, misalign_o, err_o;
    logic [63:0] mem_data_o;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;

    int err_cnt = 0;
    int chk_cnt = 0;

    mem_access_unit #(.TIMEOUT_CYC(8)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .memread_i     (memread_i),
        .memwrite_i    (memwrite_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .mem_data_o    (mem_data_o),
        .mem_valid_o   (mem_valid_o),
        .misalign_o    (misalign_o),
        .err_o         (err_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
        valid_i = 1'b1; memread_i = rd; memwrite_i = wr;
        funct3_i = f3; addr_i = a; wdata_i = wd;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        funct3_i = 3'd0; addr_i = 64'd0; wdata_i = 64'd0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 64'd0;
        #12;
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_data", mem_data_o, 64'd0);
        check("rst_req", {63'd0, dmem_req_o}, 64'd0);
        check("rst_valid", {63'd0, mem_valid_o}, 64'd0);
        rst_ni = 1'b1;
        tick();

        // LB 0x1003: three stall cycles, sign-extended 0x80.
        issue(1'b1, 1'b0, 3'd0, 64'h1003, 64'd0);
        #1 check("lb_stall0", {63'd0, stall_o}, 64'd1);
        check("lb_req0", {63'd0, dmem_req_o}, 64'd0);
        tick();
        check("lb_req", {63'd0, dmem_req_o}, 64'd1);
        check("lb_addr", dmem_addr_o, 64'h1000);
        check("lb_we", {63'd0, dmem_we_o}, 64'd0);
        check("lb_stall1", {63'd0, stall_o}, 64'd1);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        check("lb_wait_req", {63'd0, dmem_req_o}, 64'd0);
        check("lb_stall2", {63'd0, stall_o}, 64'd1);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h00000000_80000000;
        tick();
        dmem_rvalid_i = 1'b0;
        idle_inputs();
        #1 check("lb_valid", {63'd0, mem_valid_o}, 64'd1);
        check("lb_stall3", {63'd0, stall_o}, 64'd0);
        check("lb_data", mem_data_o, 64'hFFFFFFFF_FFFFFF80);
        tick();
        check("lb_valid_end", {63'd0, mem_valid_o}, 64'd0);
        check("lb_hold", mem_data_o, 64'hFFFFFFFF_FFFFFF80);

        // SH 0x2006: upper lanes, data must not disturb the load result.
        issue(1'b0, 1'b1, 3'd1, 64'h2006, 64'hABCD);
        tick();
        check("sh_be", {56'd0, dmem_be_o}, 64'hC0);
        check("sh_wdata", dmem_wdata_o, 64'hABCD0000_00000000);
        check("sh_addr", dmem_addr_o, 64'h2000);
        check("sh_we", {63'd0, dmem_we_o}, 64'd1);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        idle_inputs();
        #1 check("sh_valid", {63'd0, mem_valid_o}, 64'd1);
        check("sh_stall", {63'd0, stall_o}, 64'd0);
        check("sh_data_keep", mem_data_o, 64'hFFFFFFFF_FFFFFF80);
        tick();

        // Misaligned / illegal accesses flag combinationally with no request.
        issue(1'b1, 1'b0, 3'd2, 64'h1002, 64'd0);
        #1 check("lw_mis", {63'd0, misalign_o}, 64'd1);
        check("lw_mis_stall", {63'd0, stall_o}, 64'd0);
        tick();
        check("lw_mis_req", {63'd0, dmem_req_o}, 64'd0);
        check("lw_mis_valid", {63'd0, mem_valid_o}, 64'd0);
        issue(1'b1, 1'b0, 3'd7, 64'h1000, 64'd0);
        #1 check("f3_7_mis", {63'd0, misalign_o}, 64'd1);
        issue(1'b0, 1'b1, 3'd4, 64'h1000, 64'd0);
        #1 check("sbu_mis", {63'd0, misalign_o}, 64'd1);
        issue(1'b1, 1'b0, 3'd3, 64'h1000, 64'd0);
        valid_i = 1'b0;
        #1 check("novalid_mis", {63'd0, misalign_o}, 64'd0);

        // Non-memory instruction passes without stall.
        issue(1'b0, 1'b0, 3'd0, 64'h1003, 64'd0);
        #1 check("nonmem_stall", {63'd0, stall_o}, 64'd0);
        tick();
        check("nonmem_req", {63'd0, dmem_req_o}, 64'd0);
        check("nonmem_valid", {63'd0, mem_valid_o}, 64'd0);

        // LD with grant delayed 4 cycles and rvalid 2 cycles later; early rvalid ignored.
        issue(1'b1, 1'b0, 3'd3, 64'h3008, 64'd0);
        tick();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            check("ld_req_hold", {63'd0, dmem_req_o}, 64'd1);
            check("ld_addr_hold", dmem_addr_o, 64'h3008);
            check("ld_stall_req", {63'd0, stall_o}, 64'd1);
            tick();
            dmem_rvalid_i = 1'b0;
        end
        check("ld_req_gnt", {63'd0, dmem_req_o}, 64'd1);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        check("ld_stall_w0", {63'd0, stall_o}, 64'd1);
        tick();
        check("ld_stall_w1", {63'd0, stall_o}, 64'd1);
        check("ld_nodone", {63'd0, mem_valid_o}, 64'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h11223344_55667788;
        tick();
        dmem_rvalid_i = 1'b0;
        idle_inputs();
        #1 check("ld_valid", {63'd0, mem_valid_o}, 64'd1);
        check("ld_data", mem_data_o, 64'h11223344_55667788);
        tick();

        // LWU that never gets a grant: timeout after 8 REQ cycles zeroes the result.
        issue(1'b1, 1'b0, 3'd6, 64'h4004, 64'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("to_req", {63'd0, dmem_req_o}, 64'd1);
            check("to_err_early", {63'd0, err_o}, 64'd0);
            tick();
        end
        idle_inputs();
        #1 check("to_err", {63'd0, err_o}, 64'd1);
        check("to_data", mem_data_o, 64'd0);
        check("to_req_low", {63'd0, dmem_req_o}, 64'd0);
        tick();
        check("to_err_end", {63'd0, err_o}, 64'd0);

        // LBU 0x5001: zero-extended byte lane 1.
        issue(1'b1, 1'b0, 3'd4, 64'h5001, 64'd0);
        tick();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h00000000_0000F000;
        tick();
        dmem_rvalid_i = 1'b0;
        idle_inputs();
        #1 check("lbu_data", mem_data_o, 64'h00000000_000000F0);
        tick();

        // LH reset while waiting for read data; late response must be ignored.
        issue(1'b1, 1'b0, 3'd1, 64'h6002, 64'd0);
        tick();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        idle_inputs();
        check("rw_in_wait", {63'd0, stall_o}, 64'd1);
        rst_ni = 1'b0;
        #1 check("rw_stall", {63'd0, stall_o}, 64'd0);
        check("rw_data", mem_data_o, 64'd0);
        check("rw_addr", dmem_addr_o, 64'd0);
        check("rw_req", {63'd0, dmem_req_o}, 64'd0);
        tick();
        rst_ni = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        dmem_rvalid_i = 1'b0;
        check("rw_late_valid", {63'd0, mem_valid_o}, 64'd0);
        check("rw_late_data", mem_data_o, 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
